signature_analyzer: RTL
=======================

SIGNATURE_ANALYZER -- requirements
Module: signature_analyzer

Interface
REQ-001 Parameter: GOLDEN, 16'h0000, expected final MISR signature for a good circuit.
REQ-002 Parameter: NCLOCK, 650, expected number of compacted test cycles.
REQ-003 Parameter: SEED, 16'hFFFF, MISR value loaded on init.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 init  input  1  from the BIST controller; requests a reseed and restart.
REQ-007 running  input  1  from the BIST controller; high while test patterns are applied.
REQ-008 finish  input  1  from the BIST controller; test sequence complete.
REQ-009 cut_out  input  8  response byte from the circuit under test, sampled when compacting.
REQ-010 signature  output  16  current MISR contents.
REQ-011 cycle_count  output  10  number of cycles compacted since the last init.
REQ-012 done  output  1  verdict valid.
REQ-013 pass  output  1  verdict; meaningful only while done=1.

Function
REQ-014 The FSM SHALL have states IDLE, ARMED, COMPACT, CHECK and DONE, and SHALL be held in registers only.
- IDLE->ARMED on init=1.
- ARMED->COMPACT on running=1.
- COMPACT->CHECK on finish=1 or running=0.
- CHECK->DONE unconditionally.
- DONE holds until init=1.
REQ-015 init=1 in any state SHALL move the FSM to ARMED on that edge, load signature=SEED, clear cycle_count and clear done and pass.
REQ-016 init SHALL take priority over finish and running when both are sampled on the same edge.
REQ-017 The MISR SHALL compact on every edge where state is COMPACT (or ARMED entering COMPACT) and running=1.
- fb = sig[15]^sig[14]^sig[12]^sig[3].
- Next signature = {sig[14:0],fb} XOR {8'h00,cut_out}.
REQ-018 An edge with running=1 and finish=1 together in COMPACT SHALL compact that cycle, then enter CHECK.
REQ-019 cycle_count SHALL increment once per compaction and saturate at 1023 without wrapping.
REQ-020 In CHECK, the block SHALL compute pass = (signature==GOLDEN) AND (cycle_count==NCLOCK), subject to REQ-027.
- The result SHALL be registered into pass with done=1 on the edge leaving CHECK.
- done SHALL therefore rise exactly 2 edges after finish is sampled.
REQ-021 signature and cycle_count SHALL stay frozen outside COMPACT and while running=0.
REQ-022 finish sampled while in IDLE or DONE SHALL be ignored.
REQ-023 finish sampled while in ARMED SHALL go to CHECK with cycle_count=0, giving pass=0 when NCLOCK>0.
REQ-024 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-025 reset=0 sampled at an edge SHALL force IDLE, signature=16'h0000, cycle_count=0, done=0 and pass=0, overriding all other inputs.
REQ-026 After reset deasserts, the block SHALL ignore running and finish until init=1 is sampled.

Configuration
REQ-027 Macro CYCLE_CHECK_EN:
- Defined: the cycle counter exists, and pass requires cycle_count==NCLOCK.
- Undefined: the counter logic is omitted, cycle_count is tied to 0, and pass = (signature==GOLDEN) only.

Verification
REQ-028 Directed scenarios:
- Good run: reset low 2 cycles; init 1 cycle; running 650 cycles with cut_out=8'h00; finish; GOLDEN = model signature of 650 shifts from 16'hFFFF -> done=1 two edges after finish, pass=1, cycle_count=650.
- Fault: same as the good run with cut_out=8'h01 in cycle 300 -> done=1, pass=0, signature != GOLDEN.
- Short run: running 649 cycles -> cycle_count=649 and pass=0 (CYCLE_CHECK_EN defined); with the macro undefined -> cycle_count=0.
- Mid-run reset: reset=0 at compact cycle 50 -> next edge signature=0, cycle_count=0, done=0; a following running/finish without init -> done stays 0.
- Mid-run init: init at compact cycle 100, then 650 clean cycles and finish -> pass=1, cycle_count=650.
- Simultaneous init and finish in COMPACT -> state ARMED, signature=16'hFFFF, done stays 0.

Source files
------------

// File: rtl/signature_analyzer.sv
// -----------------------------------------------------------------------------
// signature_analyzer
//
// Purpose:
//   BIST response compactor. A 16-bit MISR folds the response byte of the
//   circuit under test into a running signature while the BIST controller
//   applies patterns. When the run ends, the signature (and optionally the
//   number of compacted cycles) is compared against the expected good-circuit
//   values. The result is published as a registered pass/done verdict.
//
// Parameters:
//   GOLDEN  expected final signature of a good circuit
//   NCLOCK  expected number of compacted cycles
//   SEED    signature value loaded on init
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   reset        synchronous, active-low reset
//   init         reseed request from the BIST controller (restarts the run)
//   running      high while test patterns are being applied
//   finish       end of the test sequence
//   cut_out      response byte from the circuit under test
//   signature    current MISR contents
//   cycle_count  cycles compacted since the last init (saturates at 1023)
//   done         verdict valid
//   pass         verdict, meaningful only while done is high
//
// Configuration macro:
//   CYCLE_CHECK_EN  when defined, a saturating cycle counter is built and the
//                   verdict also requires cycle_count == NCLOCK. When left
//                   undefined, the counter is omitted, cycle_count reads 0 and
//                   the verdict depends on the signature alone.
// -----------------------------------------------------------------------------
module signature_analyzer #(
  parameter logic [15:0] GOLDEN = 16'h0000,
  parameter int          NCLOCK = 650,
  parameter logic [15:0] SEED   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        running,
  input  logic        finish,
  input  logic [7:0]  cut_out,
  output logic [15:0] signature,
  output logic [9:0]  cycle_count,
  output logic        done,
  output logic        pass
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COMPACT,
    CHECK,
    DONE
  } state_t;

  state_t state;

`ifdef CYCLE_CHECK_EN
  localparam bit CYCLE_CHECK = 1'b1;
`else
  localparam bit CYCLE_CHECK = 1'b0;
`endif

  logic        fb;
  logic [15:0] sig_next;
  logic        compact_en;
  logic        verdict;

  // MISR next state: shift left with the tap feedback in bit 0, then fold
  // the response byte into the low half.
  assign fb       = signature[15] ^ signature[14] ^ signature[12] ^ signature[3];
  assign sig_next = {signature[14:0], fb} ^ {8'h00, cut_out};

  // Compaction happens on the edge that leaves ARMED for COMPACT as well as
  // inside COMPACT. A finish seen in ARMED ends the run before any cycle is
  // compacted, so it suppresses compaction there.
  assign compact_en = running &&
                      ((state == COMPACT) || ((state == ARMED) && !finish));

  // When the counter is not built, CYCLE_CHECK is a constant 0 and the
  // count comparison drops out of the verdict.
  assign verdict = (signature == GOLDEN) &&
                   (!CYCLE_CHECK || (int'(cycle_count) == NCLOCK));

`ifdef CYCLE_CHECK_EN
  // Saturating count of compacted cycles; restarted by reset or init.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (init) begin
      cycle_count <= '0;
    end else if (compact_en && (cycle_count != 10'h3FF)) begin
      cycle_count <= cycle_count + 10'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

  // Controller, MISR and verdict registers. Reset beats init, and init beats
  // everything else, so a reseed always lands in ARMED with a clean verdict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      signature <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (init) begin
      state     <= ARMED;
      signature <= SEED;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      if (compact_en) begin
        signature <= sig_next;
      end
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        ARMED: begin
          if (finish) begin
            state <= CHECK;
          end else if (running) begin
            state <= COMPACT;
          end
        end
        COMPACT: begin
          // Either an explicit finish or the controller dropping running
          // closes the run; a cycle with both running and finish has
          // already been compacted above.
          if (finish || !running) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          pass  <= verdict;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
